// File: rtl/tq_row_buf_ctrl_if.sv
// Interface bundle for tq_row_buf_ctrl.
// Carries the row-control inputs, the upstream and downstream coefficient
// handshakes, the TQ RAM port and the status outputs. The controller takes
// the slave modport. The environment side (transform stage, quantiser and
// RAM together) takes the master modport.
interface tq_row_buf_ctrl_if #(
   parameter int DW = 16,
   parameter int AW = 5
);
   // row control
   logic          start;
   logic [1:0]    size;
   logic          rev;
   // upstream coefficient stream
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   // downstream coefficient stream
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_ready;
   // status
   logic          done;
   logic          busy;
   logic [15:0]   stall_cnt;
   // single-port RAM, low-active controls
   logic          ram_cen;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  start, size, rev, in_valid, in_data, out_ready, ram_rdata,
      output in_ready, out_valid, out_data, out_last, done, busy, stall_cnt,
             ram_cen, ram_wen, ram_addr, ram_wdata
   );

   modport master (
      output start, size, rev, in_valid, in_data, out_ready, ram_rdata,
      input  in_ready, out_valid, out_data, out_last, done, busy, stall_cnt,
             ram_cen, ram_wen, ram_addr, ram_wdata
   );
endinterface

// File: rtl/tq_row_buf_ctrl.sv
// tq_row_buf_ctrl: row buffer sequencer in front of a 32x16 single-port
// TQ coefficient RAM.
// The controller captures one row of 4/8/16/32 coefficients from the 1-D
// transform stage. It then replays the row to the quantiser in natural or
// reversed order. The RAM has a 1-cycle registered read and holds its read
// data while cen is high. The controller relies on that hold so that it can
// park a fetched coefficient during downstream back-pressure.
// Optional build macro TQ_ROW_BUF_STALL_CNT_EN adds a saturating counter of
// output back-pressure cycles on stall_cnt. Without the macro, stall_cnt
// is tied to zero.
module tq_row_buf_ctrl #(
   parameter int DW = 16,
   parameter int AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   tq_row_buf_ctrl_if.slave  bus
);

   // 6-bit counters so that a 32-entry row does not wrap to zero
   localparam int CW = 6;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ,
      DRAIN,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] len;         // N for the current row
   logic [CW-1:0] len_m1;      // N-1, index of the final element
   logic [CW-1:0] wr_cnt;      // coefficients written so far
   logic [CW-1:0] iss_cnt;     // RAM reads issued so far
   logic          rev_q;
   logic          rd_pend;     // a read result is waiting on ram_rdata
   logic          in_ready_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic [DW-1:0] out_data_q;
   logic          done_q;
   logic          busy_q;
   logic [AW-1:0] addr_q;      // last address driven, held between accesses
   logic [DW-1:0] wdata_q;     // last write data driven, held between writes

   logic          wr_fire;
   logic          out_hs;
   logic          slot_free;
   logic          rd_issue;
   logic          rd_load;
   logic [AW-1:0] rd_addr;
   logic          ram_cen;
   logic          ram_wen;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;

   assign len_m1 = len - CW'(1);

   // Handshake qualifiers and read-issue decision for the current cycle.
   // NOTE: every signal gets a value on every path through always_comb, so
   // no latch can be inferred.
   always_comb begin
      // in_ready is only ever high in WRITE, so stray in_valid elsewhere is dropped
      wr_fire   = in_ready_q & bus.in_valid;
      out_hs    = out_valid_q & bus.out_ready;
      // the output register is free now or is emptied by this cycle's handshake
      slot_free = ~out_valid_q | bus.out_ready;
      rd_issue  = (state == READ) && (iss_cnt < len) && slot_free;
      // a parked read result moves into the output register once the slot frees
      rd_load   = rd_pend & slot_free;
      rd_addr   = rev_q ? (len_m1[AW-1:0] - iss_cnt[AW-1:0]) : iss_cnt[AW-1:0];
   end

   // RAM port drive: write data is a pass-through on write cycles, and the
   // address and data hold their last values when the RAM is not accessed.
   always_comb begin
      ram_cen   = ~(wr_fire | rd_issue);
      ram_wen   = ~wr_fire;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
      if (wr_fire) begin
         ram_addr  = wr_cnt[AW-1:0];
         ram_wdata = bus.in_data;
      end else if (rd_issue) begin
         ram_addr  = rd_addr;
      end
   end

   // Row sequencer FSM with all handshake and status outputs registered.
   // NOTE: state is updated with non-blocking assignments. Every read in
   // this block therefore sees the value from before the clock edge,
   // regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         len         <= '0;
         wr_cnt      <= '0;
         iss_cnt     <= '0;
         rev_q       <= 1'b0;
         rd_pend     <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
      end else begin
         done_q <= 1'b0;

         if (wr_fire || rd_issue)
            addr_q <= ram_addr;
         if (wr_fire)
            wdata_q <= bus.in_data;

         // at most one read is ever outstanding; issue and load can coincide
         if (rd_issue)
            rd_pend <= 1'b1;
         else if (rd_load)
            rd_pend <= 1'b0;

         // output register: load takes priority over the clear from a handshake
         if (rd_load) begin
            out_data_q  <= bus.ram_rdata;
            out_valid_q <= 1'b1;
            // only the final element can still be in flight once issuing has stopped
            out_last_q  <= (state == DRAIN);
         end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.start) begin
                  len        <= CW'(4) << bus.size;
                  rev_q      <= bus.rev;
                  wr_cnt     <= '0;
                  iss_cnt    <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= WRITE;
               end
            end

            WRITE: begin
               if (wr_fire) begin
                  wr_cnt <= wr_cnt + CW'(1);
                  if (wr_cnt == len_m1) begin
                     in_ready_q <= 1'b0;
                     state      <= READ;
                  end
               end
            end

            READ: begin
               if (rd_issue) begin
                  iss_cnt <= iss_cnt + CW'(1);
                  if (iss_cnt == len_m1)
                     state <= DRAIN;
               end
            end

            DRAIN: begin
               if (out_hs && out_last_q) begin
                  done_q <= 1'b1;
                  state  <= DONE;
               end
            end

            DONE: begin
               busy_q <= 1'b0;
               state  <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef TQ_ROW_BUF_STALL_CNT_EN
   logic [15:0] stall_q;

   // Back-pressure cycle counter: cleared on an accepted start, saturating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_q <= '0;
      else if (state == IDLE && bus.start)
         stall_q <= '0;
      else if (out_valid_q && !bus.out_ready && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end

   assign bus.stall_cnt = stall_q;
`else
   assign bus.stall_cnt = 16'd0;
`endif

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.done      = done_q;
   assign bus.busy      = busy_q;
   assign bus.ram_cen   = ram_cen;
   assign bus.ram_wen   = ram_wen;
   assign bus.ram_addr  = ram_addr;
   assign bus.ram_wdata = ram_wdata;

endmodule

// File: tb/tb_tq_row_buf_ctrl.sv
// Testbench for tq_row_buf_ctrl.
// The bench builds the expected RAM writes, read addresses and output
// order of each row from the row definition, and a compare process checks
// the DUT against them every cycle. A behavioural single-port RAM serves
// the DUT. Literal checks after each row pin the expected values.
module tb_tq_row_buf_ctrl;

   logic clk;
   logic rst_n;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   cyc = 0;

   tq_row_buf_ctrl_if #(.DW(16), .AW(5)) bus ();

   tq_row_buf_ctrl #(.DW(16), .AW(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural 32x16 RAM: registered read, output held while cen is high
   logic [15:0] mem [32];
   always @(posedge clk) begin
      if (!bus.ram_cen) begin
         if (!bus.ram_wen) mem[bus.ram_addr] <= bus.ram_wdata;
         else              bus.ram_rdata    <= mem[bus.ram_addr];
      end
   end

   // expected behaviour of the current row
   typedef struct packed {
      logic [4:0]  addr;
      logic [15:0] data;
   } wr_t;

   wr_t         exp_wr_q  [$];
   logic [4:0]  exp_rd_q  [$];
   logic [15:0] exp_out_q [$];
   logic [15:0] out_log   [$];
   logic [15:0] row_data  [32];
   int          hs_cnt;
   int          first_hs_cyc;
   int          last_hs_cyc;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // per-cycle comparison of the DUT against the expected row behaviour
   initial begin : compare
      bit          last_hs_prev;
      bit          stall_prev;
      logic [15:0] prev_data;
      logic        prev_last;
      bit          hs_last;
      last_hs_prev = 0;
      stall_prev   = 0;
      prev_data    = '0;
      prev_last    = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            exp_out_q.delete();
            last_hs_prev = 0;
            stall_prev   = 0;
         end else begin
            // single port: writes only while row input is pending, reads only after it
            n_cmp++;
            assert (bus.ram_cen ||
                    (!bus.ram_wen ? (exp_wr_q.size() > 0) : (exp_wr_q.size() == 0)))
            else begin
               n_fail++;
               $display("FAIL single_port: cen=%0b wen=%0b with %0d writes outstanding",
                        bus.ram_cen, bus.ram_wen, exp_wr_q.size());
            end

            if (!bus.ram_cen && !bus.ram_wen) begin
               check("write_expected", 32'(exp_wr_q.size() > 0), 1);
               if (exp_wr_q.size() > 0) begin
                  check("write_addr", 32'(bus.ram_addr), 32'(exp_wr_q[0].addr));
                  check("write_data", 32'(bus.ram_wdata), 32'(exp_wr_q[0].data));
                  void'(exp_wr_q.pop_front());
               end
            end

            if (!bus.ram_cen && bus.ram_wen) begin
               check("read_expected", 32'(exp_rd_q.size() > 0), 1);
               if (exp_rd_q.size() > 0) begin
                  check("read_addr", 32'(bus.ram_addr), 32'(exp_rd_q[0]));
                  void'(exp_rd_q.pop_front());
               end
            end

            if (stall_prev) begin
               check("stall_hold_valid", 32'(bus.out_valid), 1);
               check("stall_hold_data", 32'(bus.out_data), 32'(prev_data));
               check("stall_hold_last", 32'(bus.out_last), 32'(prev_last));
            end

            check("done_pulse", 32'(bus.done), 32'(last_hs_prev));

            hs_last = 0;
            if (bus.out_valid && bus.out_ready) begin
               check("out_expected", 32'(exp_out_q.size() > 0), 1);
               if (exp_out_q.size() > 0) begin
                  check("out_data", 32'(bus.out_data), 32'(exp_out_q[0]));
                  check("out_last", 32'(bus.out_last), 32'(exp_out_q.size() == 1));
                  hs_last = (exp_out_q.size() == 1);
                  void'(exp_out_q.pop_front());
               end
               out_log.push_back(bus.out_data);
               hs_cnt++;
               if (hs_cnt == 1) first_hs_cyc = cyc;
               last_hs_cyc = cyc;
            end

            last_hs_prev = hs_last;
            stall_prev   = bus.out_valid && !bus.out_ready;
            prev_data    = bus.out_data;
            prev_last    = bus.out_last;
         end
      end
   end

   // one row: expectations, start, input phase, output phase, end checks
   task automatic run_row(input int size, input bit rev, input bit gap, input bit junk,
                          input bit stall, input int glitch, input int rst_after);
      int  n;
      int  k;
      int  idx;
      bit  fire;
      bit  seen_done;
      bit  did_reset;
      int  stall_left;
      bit  st5;
      bit  st31;
      n = 4 << size;
      hs_cnt = 0;
      out_log.delete();
      for (int i = 0; i < n; i++) begin
         exp_wr_q.push_back({5'(i), row_data[i]});
         idx = rev ? (n - 1 - i) : i;
         exp_rd_q.push_back(5'(idx));
         exp_out_q.push_back(row_data[idx]);
      end

      bus.in_valid = junk;
      bus.in_data  = 16'hFFFF;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.size  = 2'(size);
      bus.rev   = rev;
      @(posedge clk); #1;
      bus.start = 1'b0;

      k = 0;
      for (int c = 0; c < 300 && k < n; c++) begin
         bus.start = (c == glitch);
         if (c == glitch) begin
            bus.size = 2'd3;
            bus.rev  = ~rev;
         end
         bus.in_valid = gap ? (c % 2 == 0) : 1'b1;
         bus.in_data  = row_data[k];
         fire = bus.in_valid && bus.in_ready;
         @(posedge clk); #1;
         if (fire) k++;
      end
      bus.start    = 1'b0;
      bus.in_valid = junk;
      bus.in_data  = 16'hFFFF;
      if (k < n) check("write_timeout", 32'(k), 32'(n));

      seen_done  = 0;
      did_reset  = 0;
      stall_left = 0;
      st5        = 0;
      st31       = 0;
      for (int c = 0; c < 400 && !seen_done; c++) begin
         @(posedge clk); #1;
         if (rst_after >= 0 && hs_cnt >= rst_after) begin
            rst_n = 1'b0;
            #1;
            check("rst_out_valid", 32'(bus.out_valid), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_cen", 32'(bus.ram_cen), 1);
            check("rst_in_ready", 32'(bus.in_ready), 0);
            @(negedge clk);
            @(posedge clk); #1;
            rst_n = 1'b1;
            did_reset = 1;
            break;
         end
         if (bus.done) seen_done = 1;
         if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
         end else if (stall && bus.out_valid &&
                      ((hs_cnt == 5 && !st5) || (hs_cnt == 31 && !st31))) begin
            if (hs_cnt == 5) st5 = 1;
            else st31 = 1;
            bus.out_ready = 1'b0;
            stall_left = 2;
         end else begin
            bus.out_ready = 1'b1;
         end
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b0;

      if (!did_reset) begin
         check("done_seen", 32'(seen_done), 1);
         @(negedge clk);
         @(posedge clk); #1;
         check("row_handshakes", 32'(hs_cnt), 32'(n));
         check("row_writes_left", 32'(exp_wr_q.size()), 0);
         check("row_reads_left", 32'(exp_rd_q.size()), 0);
         check("row_outs_left", 32'(exp_out_q.size()), 0);
         check("row_busy_idle", 32'(bus.busy), 0);
      end
   endtask

   initial begin : stimulus
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.size      = 2'd0;
      bus.rev       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(bus.in_ready), 0);
      check("reset_out_valid", 32'(bus.out_valid), 0);
      check("reset_out_last", 32'(bus.out_last), 0);
      check("reset_done", 32'(bus.done), 0);
      check("reset_busy", 32'(bus.busy), 0);
      check("reset_cen", 32'(bus.ram_cen), 1);
      check("reset_wen", 32'(bus.ram_wen), 1);
      check("reset_addr", 32'(bus.ram_addr), 0);
      check("reset_wdata", 32'(bus.ram_wdata), 0);
      check("reset_out_data", 32'(bus.out_data), 0);
      check("reset_stall_cnt", 32'(bus.stall_cnt), 0);
      rst_n = 1'b1;

      // basic stream, N=8
      for (int i = 0; i < 8; i++) row_data[i] = 16'h0010 + 16'(i);
      run_row(1, 0, 0, 0, 0, -1, -1);
      check("basic_first", 32'(out_log[0]), 32'h0010);
      check("basic_last", 32'(out_log[7]), 32'h0017);
      check("basic_back_to_back", 32'(last_hs_cyc - first_hs_cyc), 7);

      // reverse order, N=4, with stray in_valid outside WRITE
      row_data[0] = 16'h000A; row_data[1] = 16'h000B;
      row_data[2] = 16'h000C; row_data[3] = 16'h000D;
      run_row(0, 1, 0, 1, 0, -1, -1);
      check("rev_out0", 32'(out_log[0]), 32'h000D);
      check("rev_out1", 32'(out_log[1]), 32'h000C);
      check("rev_out2", 32'(out_log[2]), 32'h000B);
      check("rev_out3", 32'(out_log[3]), 32'h000A);

      // full depth with back-pressure at elements 5 and 31
      for (int i = 0; i < 32; i++) row_data[i] = 16'(i);
      run_row(3, 0, 0, 0, 1, -1, -1);
      check("full_out5", 32'(out_log[5]), 32'h0005);
      check("full_out31", 32'(out_log[31]), 32'h001F);
`ifdef TQ_ROW_BUF_STALL_CNT_EN
      check("stall_cnt", 32'(bus.stall_cnt), 6);
`else
      check("stall_cnt", 32'(bus.stall_cnt), 0);
`endif

      // gapped input, N=16, with a start pulse during WRITE
      for (int i = 0; i < 16; i++) row_data[i] = 16'h0100 + 16'(3 * i);
      run_row(2, 0, 1, 0, 0, 5, -1);
      check("gap_out15", 32'(out_log[15]), 32'h012D);

      // reset after 3 of 8 outputs, then a normal N=4 row
      for (int i = 0; i < 8; i++) row_data[i] = 16'h5A00 + 16'(i);
      run_row(1, 0, 0, 0, 0, -1, 3);
      for (int i = 0; i < 4; i++) row_data[i] = 16'h7000 + 16'(i);
      run_row(0, 0, 0, 0, 0, -1, -1);
      check("post_reset_count", 32'(out_log.size()), 4);
      check("post_reset_out3", 32'(out_log[3]), 32'h7003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
